// File: rtl/mips32_mem_pkg.sv
// Shared constants, enums and range helper for the MIPS32 memory responder.
package mips32_mem_pkg;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 10;

  typedef enum logic { PORT_IF = 1'b0, PORT_DM = 1'b1 } port_t;

  typedef enum logic [1:0] { S_IDLE, S_WAIT, S_RESP } state_t;

  // True when the word address indexes inside a 2**aw-word array.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned aw);
    return (addr >> aw) == 32'd0;
  endfunction

endpackage

// File: rtl/mips32_sram_1p.sv
// Single-port word array: synchronous write, registered read, no reset on contents.
module mips32_sram_1p #(
  parameter int unsigned DEPTH  = mips32_mem_pkg::DEPTH,
  parameter int unsigned ADDR_W = mips32_mem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              ce,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  // rdata is only reloaded by a read, so it holds across wait states.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mips32_mem_responder.sv
// Fetch/data memory responder: round-robin arbiter, wait-state FSM and range check
// in front of one single-port word array.
module mips32_mem_responder #(
  parameter int unsigned DEPTH       = mips32_mem_pkg::DEPTH,
  parameter int unsigned ADDR_W      = mips32_mem_pkg::ADDR_W,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        dm_req_valid,
  output logic        dm_req_ready,
  input  logic        dm_req_we,
  input  logic [31:0] dm_req_addr,
  input  logic [31:0] dm_req_wdata,
  output logic        dm_rsp_valid,
  output logic [31:0] dm_rsp_data,
  output logic        rsp_err
);
  import mips32_mem_pkg::*;

  if (WAIT_STATES > 3) begin : g_bad_wait_states
    $error("WAIT_STATES must be in 0..3");
  end

  state_t      state;
  port_t       rr_last;
  port_t       lat_port;
  logic        lat_we;
  logic        lat_err;
  logic [1:0]  wait_cnt;

  logic        grant_dm;
  logic        accept;
  logic [31:0] acc_addr;
  logic        acc_ok;
  logic        sram_ce;
  logic        sram_we;
  logic [31:0] sram_rdata;
  logic [31:0] rsp_word;
  logic        rsp_fire;

  always_comb begin
    grant_dm     = dm_req_valid && (!if_req_valid || rr_last == PORT_IF);
    if_req_ready = rst_n && (state == S_IDLE) && if_req_valid && !grant_dm;
    dm_req_ready = rst_n && (state == S_IDLE) && grant_dm;
    accept       = if_req_ready || dm_req_ready;
    acc_addr     = grant_dm ? dm_req_addr : if_req_addr;
    acc_ok       = in_range(acc_addr, ADDR_W);
    sram_ce      = accept && acc_ok;
    sram_we      = grant_dm && dm_req_we;
  end

  mips32_sram_1p #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_sram (
    .clk  (clk),
    .ce   (sram_ce),
    .we   (sram_we),
    .addr (acc_addr[ADDR_W-1:0]),
    .wdata(dm_req_wdata),
    .rdata(sram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr_last  <= PORT_IF;
      lat_port <= PORT_IF;
      lat_we   <= 1'b0;
      lat_err  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_port <= grant_dm ? PORT_DM : PORT_IF;
            rr_last  <= grant_dm ? PORT_DM : PORT_IF;
            lat_we   <= sram_we;
            lat_err  <= !acc_ok;
            wait_cnt <= 2'(WAIT_STATES - 1);
            state    <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) state <= S_RESP;
          else                wait_cnt <= wait_cnt - 2'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Responses decode straight from registered state; the data word comes from the
  // array's own output register, which is what keeps zero-wait latency at one cycle.
  always_comb begin
    rsp_fire     = (state == S_RESP);
    rsp_word     = (lat_we || lat_err) ? '0 : sram_rdata;
    if_rsp_valid = rsp_fire && (lat_port == PORT_IF);
    dm_rsp_valid = rsp_fire && (lat_port == PORT_DM);
    if_rsp_data  = if_rsp_valid ? rsp_word : '0;
    dm_rsp_data  = dm_rsp_valid ? rsp_word : '0;
    rsp_err      = rsp_fire && lat_err;
  end

  a_if_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (if_req_valid && !if_req_ready) |=> (!if_req_valid || $stable(if_req_addr)));

  a_dm_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (dm_req_valid && !dm_req_ready) |=>
      (!dm_req_valid || ($stable(dm_req_addr) && $stable(dm_req_we) && $stable(dm_req_wdata))));

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Directed bench for mips32_mem_responder: zero-wait instance for function/arbitration/
// reset cases, three-wait instance for latency and back-pressure timing.
module tb_mips32_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        if_req_valid = 1'b0, if_req_ready, if_rsp_valid;
  logic [31:0] if_req_addr = '0, if_rsp_data;
  logic        dm_req_valid = 1'b0, dm_req_ready, dm_req_we = 1'b0, dm_rsp_valid;
  logic [31:0] dm_req_addr = '0, dm_req_wdata = '0, dm_rsp_data;
  logic        rsp_err;

  logic        if_req_valid3 = 1'b0, if_req_ready3, if_rsp_valid3;
  logic [31:0] if_req_addr3 = '0, if_rsp_data3;
  logic        dm_req_valid3 = 1'b0, dm_req_ready3, dm_req_we3 = 1'b0, dm_rsp_valid3;
  logic [31:0] dm_req_addr3 = '0, dm_req_wdata3 = '0, dm_rsp_data3;
  logic        rsp_err3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips32_mem_responder #(.WAIT_STATES(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_we(dm_req_we),
    .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data), .rsp_err(rsp_err)
  );

  mips32_mem_responder #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid3), .if_req_ready(if_req_ready3), .if_req_addr(if_req_addr3),
    .if_rsp_valid(if_rsp_valid3), .if_rsp_data(if_rsp_data3),
    .dm_req_valid(dm_req_valid3), .dm_req_ready(dm_req_ready3), .dm_req_we(dm_req_we3),
    .dm_req_addr(dm_req_addr3), .dm_req_wdata(dm_req_wdata3),
    .dm_rsp_valid(dm_rsp_valid3), .dm_rsp_data(dm_rsp_data3), .rsp_err(rsp_err3)
  );

  typedef struct {
    logic        dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int unsigned i);
    return 32'h1000_0000 + i * 32'h0101;
  endfunction

  // One complete access on the zero-wait instance; request stays up during the
  // response cycle so the low readies there are meaningful.
  task automatic access(input string name, input logic dm, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_err,
                        output logic [31:0] data);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    if (dm) begin
      dm_req_valid = 1'b1; dm_req_we = we; dm_req_addr = addr; dm_req_wdata = wdata;
    end else begin
      if_req_valid = 1'b1; if_req_addr = addr;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (dm ? dm_req_ready : if_req_ready) begin
        got = 1'b1;
        break;
      end
    end
    check($sformatf("%s.accept", name), 32'(got), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check($sformatf("%s.ready_low", name), 32'({if_req_ready, dm_req_ready}), 32'd0);
    check($sformatf("%s.rsp_valid", name), 32'({if_rsp_valid, dm_rsp_valid}),
          dm ? 32'd1 : 32'd2);
    data = dm ? dm_rsp_data : if_rsp_data;
    check($sformatf("%s.rsp_data", name), data, exp_data);
    check($sformatf("%s.rsp_err", name), 32'(rsp_err), 32'(exp_err));
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[10];
    logic [31:0] model[16];
    logic [31:0] d, sum_dut, sum_model;
    logic        grants[6];
    int          ng, both;
    logic        got;

    vt[0] = '{1'b1, 1'b1, 32'd5,          32'h2801000A, 32'h0,        1'b0};
    vt[1] = '{1'b0, 1'b0, 32'd5,          32'h0,        32'h2801000A, 1'b0};
    vt[2] = '{1'b1, 1'b1, 32'd12,         32'hDEADBEEF, 32'h0,        1'b0};
    vt[3] = '{1'b1, 1'b0, 32'd12,         32'h0,        32'hDEADBEEF, 1'b0};
    vt[4] = '{1'b0, 1'b0, 32'd12,         32'h0,        32'hDEADBEEF, 1'b0};
    vt[5] = '{1'b1, 1'b0, 32'h0000_0400,  32'h0,        32'h0,        1'b1};
    vt[6] = '{1'b1, 1'b1, 32'h0000_0800,  32'h12345678, 32'h0,        1'b1};
    vt[7] = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'h0,        32'h0,        1'b1};
    vt[8] = '{1'b1, 1'b1, 32'h0000_03FF,  32'hCAFEF00D, 32'h0,        1'b0};
    vt[9] = '{1'b1, 1'b0, 32'h0000_03FF,  32'h0,        32'hCAFEF00D, 1'b0};

    // Reset values, checked while reset is held with both requests pending.
    if_req_valid = 1'b1; dm_req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.ready", 32'({if_req_ready, dm_req_ready}), 32'd0);
    check("reset.rsp", 32'({if_rsp_valid, dm_rsp_valid, rsp_err}), 32'd0);
    check("reset.data", if_rsp_data | dm_rsp_data, 32'd0);
    if_req_valid = 1'b0; dm_req_valid = 1'b0;
    do_reset();

    // Round-robin from reset, both ports continuously requesting.
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = 32'd1;
    dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 32'd2;
    ng = 0; both = 0;
    for (int c = 0; c < 30 && ng < 6; c++) begin
      @(negedge clk);
      if (if_req_ready && dm_req_ready) both++;
      if (dm_req_ready)      begin grants[ng] = 1'b1; ng++; end
      else if (if_req_ready) begin grants[ng] = 1'b0; ng++; end
    end
    @(posedge clk); #1;
    if_req_valid = 1'b0; dm_req_valid = 1'b0;
    check("rr.count", 32'(ng), 32'd6);
    check("rr.both_ready", 32'(both), 32'd0);
    for (int i = 0; i < ng; i++)
      check($sformatf("rr.grant%0d_is_dm", i), 32'(grants[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
    repeat (2) @(posedge clk);

    // Three wait states: store then load of word 7 on the second instance.
    #1;
    dm_req_valid3 = 1'b1; dm_req_we3 = 1'b1; dm_req_addr3 = 32'd7; dm_req_wdata3 = 32'h77;
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      got = dm_req_ready3;
    end
    check("ws3.store_accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    dm_req_valid3 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    dm_req_valid3 = 1'b1; dm_req_we3 = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      got = dm_req_ready3;
    end
    check("ws3.load_accept", 32'(got), 32'd1);
    for (int unsigned i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("ws3.ready_low_k+%0d", i), 32'({if_req_ready3, dm_req_ready3}), 32'd0);
      check($sformatf("ws3.rsp_valid_k+%0d", i), 32'(dm_rsp_valid3), (i == 4) ? 32'd1 : 32'd0);
      if (i == 4) begin
        check("ws3.rsp_data", dm_rsp_data3, 32'h77);
        check("ws3.rsp_err", 32'(rsp_err3), 32'd0);
      end
    end
    @(negedge clk);
    check("ws3.next_accept_k+5", 32'(dm_req_ready3), 32'd1);
    @(posedge clk); #1;
    dm_req_valid3 = 1'b0;
    repeat (6) @(posedge clk);

    // Known pattern into words 0..15 through the data port.
    for (int unsigned i = 0; i < 16; i++) begin
      model[i] = pat(i);
      access($sformatf("pre%0d", i), 1'b1, 1'b1, 32'(i), pat(i), 32'h0, 1'b0, d);
    end

    for (int i = 0; i < 10; i++) begin
      access($sformatf("vec%0d", i), vt[i].dm, vt[i].we, vt[i].addr, vt[i].wdata,
             vt[i].exp_data, vt[i].exp_err, d);
      if (vt[i].dm && vt[i].we && vt[i].addr < 32'd16) model[vt[i].addr[3:0]] = vt[i].wdata;
    end

    // Out-of-range store must not alias onto word 0 or anything else.
    sum_dut = '0; sum_model = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      access($sformatf("sum%0d", i), 1'b1, 1'b0, 32'(i), 32'h0, model[i], 1'b0, d);
      sum_dut   = sum_dut + d;
      sum_model = sum_model + model[i];
    end
    check("checksum", sum_dut, sum_model);

    // Reset one cycle after accepting a load: the response must never appear.
    @(posedge clk); #1;
    dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 32'd3;
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      got = dm_req_ready;
    end
    check("rst.accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; dm_req_valid = 1'b0;
    both = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (if_rsp_valid || dm_rsp_valid || rsp_err) both++;
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (if_rsp_valid || dm_rsp_valid || rsp_err) both++;
    end
    check("rst.no_rsp", 32'(both), 32'd0);
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = 32'd5;
    dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 32'd12;
    @(negedge clk);
    check("rst.first_grant", 32'({if_req_ready, dm_req_ready}), 32'd1);
    @(posedge clk); #1;
    if_req_valid = 1'b0; dm_req_valid = 1'b0;
    @(negedge clk);
    check("rst.dm_rsp", 32'({dm_rsp_valid, if_rsp_valid}), 32'd2);
    check("rst.dm_data", dm_rsp_data, 32'hDEADBEEF);
    access("rst.word5", 1'b0, 1'b0, 32'd5, 32'h0, 32'h2801000A, 1'b0, d);
    access("rst.word3", 1'b1, 1'b0, 32'd3, 32'h0, pat(3), 1'b0, d);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
